// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default widths for the pipeline stage-sequencing controller.
package pipe_ctrl_pkg;

    localparam int MASK_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;
    localparam int REG_IDX_W  = 3;

    typedef enum logic {
        ST_RUN,
        ST_MULTI
    } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Event inputs and stage controls exchanged between the pipeline and its sequencer.
interface pipeline_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int MASK_W = MASK_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    logic                 hdu_stall;
    logic                 redirect_valid;
    logic                 mem_busy;
    logic                 mult_start;
    logic [MASK_W-1:0]    mult_mask;

    logic                 pc_wr;
    logic                 pc_sel;
    logic                 fd_en;
    logic                 dr_en;
    logic                 re_en;
    logic                 em_en;
    logic                 mw_en;
    logic                 bubble_fd;
    logic                 bubble_dr;
    logic                 bubble_re;
    logic                 bubble_em;
    logic                 bubble_mw;
    logic                 mult_active;
    logic [REG_IDX_W-1:0] mult_reg;
    logic [REG_IDX_W-1:0] mult_offset;
    logic                 mult_last;
    logic [CNT_W-1:0]     stall_cycles;

    // The controller is the master: it consumes events and drives stage controls.
    modport master (
        input  hdu_stall, redirect_valid, mem_busy, mult_start, mult_mask,
        output pc_wr, pc_sel, fd_en, dr_en, re_en, em_en, mw_en,
               bubble_fd, bubble_dr, bubble_re, bubble_em, bubble_mw,
               mult_active, mult_reg, mult_offset, mult_last, stall_cycles
    );

    modport slave (
        output hdu_stall, redirect_valid, mem_busy, mult_start, mult_mask,
        input  pc_wr, pc_sel, fd_en, dr_en, re_en, em_en, mw_en,
               bubble_fd, bubble_dr, bubble_re, bubble_em, bubble_mw,
               mult_active, mult_reg, mult_offset, mult_last, stall_cycles
    );

endinterface

// File: rtl/pipeline_ctrl_mask_pick.sv
// Lowest-set-bit encoder for LM/SM micro-sequencing: index, remaining mask, last flag.
module mask_pick
    import pipe_ctrl_pkg::*;
#(
    parameter int MASK_W = MASK_W_DEF
) (
    input  logic [MASK_W-1:0]    i_mask,
    output logic [REG_IDX_W-1:0] o_idx,
    output logic [MASK_W-1:0]    o_cleared,
    output logic                 o_one
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = REG_IDX_W'(i);
            end
        end
    end

    assign o_cleared = i_mask & (i_mask - MASK_W'(1));
    assign o_one     = (i_mask != '0) && (o_cleared == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stage sequencer: arbitrates memory back-pressure, redirects, LM/SM and load-use stalls.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MASK_W = MASK_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.master  ctrl_bus
);

    state_t               r_state;
    logic [MASK_W-1:0]    r_mask;
    logic [REG_IDX_W-1:0] r_offset;
    logic [CNT_W-1:0]     r_stallCnt;

    logic [REG_IDX_W-1:0] w_idx;
    logic [MASK_W-1:0]    w_cleared;
    logic                 w_one;
    logic                 w_pcWr;
    logic                 w_multGo;

    mask_pick #(.MASK_W(MASK_W)) u_maskPick (
        .i_mask    (r_mask),
        .o_idx     (w_idx),
        .o_cleared (w_cleared),
        .o_one     (w_one)
    );

    assign w_multGo              = ctrl_bus.mult_start && (ctrl_bus.mult_mask != '0);
    assign ctrl_bus.pc_wr        = w_pcWr;
    assign ctrl_bus.stall_cycles = r_stallCnt;

    // Priority chain: reset drain, mem_busy, redirect, MULTI, LM/SM entry, load-use.
    always_comb begin
        w_pcWr               = 1'b1;
        ctrl_bus.pc_sel      = 1'b0;
        ctrl_bus.fd_en       = 1'b1;
        ctrl_bus.dr_en       = 1'b1;
        ctrl_bus.re_en       = 1'b1;
        ctrl_bus.em_en       = 1'b1;
        ctrl_bus.mw_en       = 1'b1;
        ctrl_bus.bubble_fd   = 1'b0;
        ctrl_bus.bubble_dr   = 1'b0;
        ctrl_bus.bubble_re   = 1'b0;
        ctrl_bus.bubble_em   = 1'b0;
        ctrl_bus.bubble_mw   = 1'b0;
        ctrl_bus.mult_active = 1'b0;
        ctrl_bus.mult_reg    = '0;
        ctrl_bus.mult_offset = '0;
        ctrl_bus.mult_last   = 1'b0;
        if (!rst) begin
            w_pcWr             = 1'b0;
            ctrl_bus.bubble_fd = 1'b1;
            ctrl_bus.bubble_dr = 1'b1;
            ctrl_bus.bubble_re = 1'b1;
            ctrl_bus.bubble_em = 1'b1;
            ctrl_bus.bubble_mw = 1'b1;
        end else if (ctrl_bus.mem_busy) begin
            w_pcWr             = 1'b0;
            ctrl_bus.fd_en     = 1'b0;
            ctrl_bus.dr_en     = 1'b0;
            ctrl_bus.re_en     = 1'b0;
            ctrl_bus.em_en     = 1'b0;
            ctrl_bus.bubble_mw = 1'b1;
        end else if (ctrl_bus.redirect_valid) begin
            ctrl_bus.pc_sel    = 1'b1;
            ctrl_bus.bubble_fd = 1'b1;
            ctrl_bus.bubble_dr = 1'b1;
            ctrl_bus.bubble_re = 1'b1;
        end else if (r_state == ST_MULTI) begin
            w_pcWr               = 1'b0;
            ctrl_bus.fd_en       = 1'b0;
            ctrl_bus.dr_en       = 1'b0;
            ctrl_bus.mult_active = 1'b1;
            ctrl_bus.mult_reg    = w_idx;
            ctrl_bus.mult_offset = r_offset;
            ctrl_bus.mult_last   = w_one;
        end else if (w_multGo || ctrl_bus.hdu_stall) begin
            w_pcWr             = 1'b0;
            ctrl_bus.fd_en     = 1'b0;
            ctrl_bus.dr_en     = 1'b0;
            ctrl_bus.bubble_re = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_mask     <= '0;
            r_offset   <= '0;
            r_stallCnt <= '0;
        end else begin
            if (!w_pcWr && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if (ctrl_bus.mem_busy) begin
                r_state  <= r_state;
            end else if (ctrl_bus.redirect_valid) begin
                r_state  <= ST_RUN;
                r_mask   <= '0;
                r_offset <= '0;
            end else if (r_state == ST_MULTI) begin
                r_mask   <= w_cleared;
                r_offset <= w_one ? '0 : r_offset + REG_IDX_W'(1);
                if (w_one) begin
                    r_state <= ST_RUN;
                end
            end else if (w_multGo) begin
                r_state  <= ST_MULTI;
                r_mask   <= ctrl_bus.mult_mask;
                r_offset <= '0;
            end
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stage-sequencing controller for the five-register IITB-RISC pipeline (fetch→decode→regread→execute→memaccess→writeback). It drives the PC write enable, the PC source select, and per-register load-enable and bubble controls. It arbitrates between four events: load-use stalls from the hazard unit, branch/jump redirects from execute, memory back-pressure, and LM/SM multi-register micro-sequencing. It replaces the ad-hoc `~should_stall` wiring at the processor top level.

## Interface
Parameters:
- MASK_W, 8, LM/SM register-mask width, one bit per architectural register
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-low
- hdu_stall  in  1  load-use hazard from the hazard detection unit
- redirect_valid  in  1  execute resolved a taken branch or jump this cycle
- mem_busy  in  1  memaccess stage cannot complete this cycle
- mult_start  in  1  LM/SM instruction is present in the regread stage
- mult_mask  in  MASK_W  register mask of that LM/SM
- pc_wr  out  1  PC register load enable
- pc_sel  out  1  0 = sequential next PC, 1 = redirect target
- fd_en, dr_en, re_en, em_en, mw_en  out  1 each  pipeline-register load enables
- bubble_fd, bubble_dr, bubble_re, bubble_em, bubble_mw  out  1 each  the register loads a NOP (valid=0) instead of the upstream data
- mult_active  out  1  a micro-op is being issued this cycle
- mult_reg  out  3  register index of the current micro-op
- mult_offset  out  3  micro-op sequence number (0-based) used for address offset
- mult_last  out  1  current micro-op is the final one
- stall_cycles  out  CNT_W  saturating count of cycles with pc_wr=0 since reset

## Operation
- The FSM has two states: RUN and MULTI. Outputs are combinational from the state, the registered remaining mask, and the inputs.
- While rst=0 (sampled by clk): state←RUN, remaining mask←0, offset←0, stall_cycles←0. Outputs during rst=0 are forced to: pc_wr=0, pc_sel=0, all *_en=1, all bubble_*=1, and mult_* all 0. This drains every pipeline register to NOP.
- Default (RUN, no events): pc_wr=1, pc_sel=0, all *_en=1, all bubble_*=0.
- Event priority is mem_busy > redirect_valid > mult_start/MULTI > hdu_stall.
- mem_busy=1, in any state:
  - pc_wr=0 and fd/dr/re/em_en=0.
  - mw_en=1 with bubble_mw=1.
  - The FSM state, mask and offset hold.
  - A redirect or mult_start arriving in the same cycle is ignored; the source re-presents it next cycle.
- redirect_valid=1 (no mem_busy):
  - pc_wr=1, pc_sel=1, all enables 1, and bubble_fd=bubble_dr=bubble_re=1.
  - In MULTI, the sequence is aborted: state←RUN, mask←0, offset←0.
  - A mult_start in the same cycle is dropped.
- mult_start=1 in RUN with mult_mask≠0:
  - pc_wr=0, fd_en=dr_en=0, bubble_re=1.
  - Latch mult_mask, offset←0, state←MULTI.
- mult_start with mult_mask=0 is treated as a normal instruction: no stall and no MULTI entry.
- MULTI, each cycle:
  - mult_active=1.
  - mult_reg = index of the lowest set bit in the remaining mask.
  - mult_offset = offset.
  - re_en=1 with bubble_re=0, so the micro-op loads into the regread→execute register.
  - pc_wr=0, fd_en=dr_en=0.
  - Clear that bit and increment offset.
  - When exactly one bit remains: mult_last=1 and state←RUN.
- hdu_stall=1 in RUN (no higher event): pc_wr=0, fd_en=dr_en=0, bubble_re=1. hdu_stall is ignored in MULTI.
- stall_cycles increments on every cycle with rst=1 and pc_wr=0, and saturates at all-ones.

## Timing
- Zero-latency control: every output reflects the same-cycle inputs.
- State, mask and offset update on the next clk edge.
- An LM/SM with N set bits holds upstream for exactly N+1 cycles: 1 bubble cycle plus N micro-op cycles. Fetch resumes in the cycle after mult_last.
- mult_offset runs 0..N-1 with no wrap, since N≤8.
- A redirect in the same cycle as mult_last still aborts. It overrides, so mult_last is suppressed and no micro-op is issued.
- Reset asserted mid-MULTI takes effect at the next edge and leaves no residual mask.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (ST_RUN, ST_MULTI)
  - MASK_W and CNT_W defaults
  - REG_IDX_W=3
- Sub-module mask_pick: a combinational lowest-set-bit encoder that outputs index, mask-with-bit-cleared, and a one-bit-remaining flag. It is instantiated once.

## Test plan
- Reset: hold rst=0 for 2 cycles. Expect all *_en=1, all bubble_*=1, pc_wr=0, stall_cycles=0. After release, the default RUN outputs appear.
- LM with mult_mask=8'b1010_0100:
  - Cycle 0: bubble_re=1, pc_wr=0.
  - Cycles 1-3: mult_reg=2,5,7 with mult_offset=0,1,2.
  - mult_last=1 in cycle 3; pc_wr=1 in cycle 4.
  - stall_cycles=4.
- Redirect during MULTI: mask 8'hFF, then redirect_valid=1 in the 3rd micro-op cycle. Expect pc_sel=1, bubble_fd/dr/re=1, state back to RUN next cycle, and no further micro-ops.
- Simultaneous mem_busy=1, redirect_valid=1, hdu_stall=1: expect fd..em_en=0, bubble_mw=1, pc_wr=0. The redirect takes effect only when it is re-presented after mem_busy drops.
- hdu_stall for 1 cycle in RUN: expect pc_wr=0, fd_en=dr_en=0, bubble_re=1, em_en=mw_en=1. Then drive 70000 stall cycles and check stall_cycles saturates at 16'hFFFF.
